// File: rtl/fc_layer_param_if.sv
// fc_layer_param_if
//   Streaming bus for the fully-connected layer block.
//   Input side:  load_w, s_valid, data_in (word source -> layer), s_ready back.
//   Output side: m_valid, data_out (layer -> sink), m_ready back.
//   slave  modport: the layer's view.
//   master modport: the source/sink driving the layer.
interface fc_layer_param_if #(
  parameter int T = 16
);
  logic         load_w;
  logic         s_valid;
  logic         s_ready;
  logic [T-1:0] data_in;
  logic         m_valid;
  logic         m_ready;
  logic [T-1:0] data_out;

  modport slave (
    input  load_w,
    input  s_valid,
    input  data_in,
    input  m_ready,
    output s_ready,
    output m_valid,
    output data_out
  );

  modport master (
    output load_w,
    output s_valid,
    output data_in,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  data_out
  );
endinterface

// File: rtl/fc_layer_param.sv
// fc_layer_param
//   Fully-connected layer y = sat(W*x + b), optional ReLU, computed P rows at a
//   time with one column per cycle. Coefficients (W row-major, then b) are
//   loaded with load_w=1; an inference streams N x words and returns M results
//   in row order.
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous, active-low
//   bus   - fc_layer_param_if.slave (load_w, s_valid/s_ready/data_in,
//           m_valid/m_ready/data_out)
module fc_layer_param #(
  parameter int M    = 8,
  parameter int N    = 6,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int RELU = 1
) (
  input  logic              clk,
  input  logic              reset,
  fc_layer_param_if.slave   bus
);

  localparam int AW = 2 * T + $clog2(N) + 1;
  localparam int W2 = 2 * T;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (P > 1) ? $clog2(P) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [RW-1:0] GRP_LAST = RW'(M - P);
  localparam logic [RW-1:0] ROW_STEP = RW'(P);
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(P - 1);

  // Output range expressed at accumulator width for the saturation compare.
  localparam logic signed [AW-1:0] ACC_MAX = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};

  generate
    if ((P < 1) || ((M % P) != 0)) begin : g_bad_p
      $error("fc_layer_param: M must be a multiple of P");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    LOAD_X = 3'd3,
    MAC    = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_s_ready;
  logic                r_m_valid;
  logic [T-1:0]        r_data_out;
  logic [RW-1:0]       r_row;      // load row, or first row of the active group
  logic [CW-1:0]       r_col;      // load column / MAC column
  logic [KW-1:0]       r_k;        // output buffer read index

  logic signed [T-1:0]  r_w    [M][N];
  logic signed [T-1:0]  r_b    [M];
  logic signed [T-1:0]  r_x    [N];
  logic signed [AW-1:0] r_acc  [P];
  logic signed [T-1:0]  r_obuf [P];

  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_col_last;
  logic                 w_b_last;
  logic                 w_w_last;
  logic                 w_k_last;
  logic                 w_grp_last;
  logic                 w_wr_w;
  logic                 w_wr_b;
  logic                 w_wr_x;
  logic [RW-1:0]        w_pre_base;
  logic signed [AW-1:0] w_fin [P];
  logic signed [AW-1:0] w_pre [P];

  // Saturate an accumulator to T bits, then clamp negatives when RELU is set.
  function automatic logic signed [T-1:0] sat_relu(input logic signed [AW-1:0] a);
    logic signed [T-1:0] v;
    v = (a > ACC_MAX) ? ACC_MAX[T-1:0] :
        (a < ACC_MIN) ? ACC_MIN[T-1:0] : a[T-1:0];
    return ((RELU != 0) && v[T-1]) ? {T{1'b0}} : v;
  endfunction

  assign w_in_xfer  = bus.s_valid & r_s_ready;
  assign w_out_xfer = r_m_valid & bus.m_ready;
  assign w_col_last = (r_col == COL_LAST);
  assign w_b_last   = (r_row == ROW_LAST);
  assign w_w_last   = w_b_last & w_col_last;
  assign w_k_last   = (r_k == K_LAST);
  assign w_grp_last = (r_row == GRP_LAST);

  // Bias preload targets group 0 after the x load, else the group after r_row.
  assign w_pre_base = (r_state == OUT) ? (r_row + ROW_STEP) : {RW{1'b0}};

  generate
    for (genvar k = 0; k < P; k++) begin : g_lane
      logic [RW-1:0]       w_row;
      logic [RW-1:0]       w_pre_row;
      logic signed [W2-1:0] w_prod;
      assign w_row     = r_row + RW'(k);
      assign w_pre_row = w_pre_base + RW'(k);
      assign w_prod    = W2'(r_x[r_col]) * W2'(r_w[w_row][r_col]);
      assign w_fin[k]  = r_acc[k] + {{(AW-W2){w_prod[W2-1]}}, w_prod};
      assign w_pre[k]  = {{(AW-T){r_b[w_pre_row][T-1]}}, r_b[w_pre_row]};
    end
  endgenerate

  // Next-state logic and per-cycle write strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_w      = 1'b0;
    w_wr_b      = 1'b0;
    w_wr_x      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_in_xfer) begin
          if (bus.load_w) begin
            w_wr_w      = 1'b1;
            w_state_nxt = w_w_last ? LOAD_B : LOAD_W;
          end else begin
            w_wr_x      = 1'b1;
            w_state_nxt = w_col_last ? MAC : LOAD_X;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD_W: begin
        w_wr_w      = w_in_xfer;
        w_state_nxt = (w_in_xfer && w_w_last) ? LOAD_B : LOAD_W;
      end
      LOAD_B: begin
        w_wr_b      = w_in_xfer;
        w_state_nxt = (w_in_xfer && w_b_last) ? IDLE : LOAD_B;
      end
      LOAD_X: begin
        w_wr_x      = w_in_xfer;
        w_state_nxt = (w_in_xfer && w_col_last) ? MAC : LOAD_X;
      end
      MAC: begin
        w_state_nxt = w_col_last ? OUT : MAC;
      end
      OUT: begin
        if (w_out_xfer && w_k_last) begin
          w_state_nxt = w_grp_last ? IDLE : MAC;
        end else begin
          w_state_nxt = OUT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; s_ready is registered from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ready <= (w_state_nxt == IDLE)   || (w_state_nxt == LOAD_W) ||
                   (w_state_nxt == LOAD_B) || (w_state_nxt == LOAD_X);
    end
  end

  // Coefficient/x storage, counters, accumulators and output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row      <= {RW{1'b0}};
      r_col      <= {CW{1'b0}};
      r_k        <= {KW{1'b0}};
      r_m_valid  <= 1'b0;
      r_data_out <= {T{1'b0}};
      for (int r = 0; r < M; r++) begin
        r_b[r] <= {T{1'b0}};
        for (int c = 0; c < N; c++) begin
          r_w[r][c] <= {T{1'b0}};
        end
      end
      for (int c = 0; c < N; c++) begin
        r_x[c] <= {T{1'b0}};
      end
      for (int k = 0; k < P; k++) begin
        r_acc[k]  <= {AW{1'b0}};
        r_obuf[k] <= {T{1'b0}};
      end
    end else if (w_wr_w) begin
      r_w[r_row][r_col] <= bus.data_in;
      if (w_col_last) begin
        r_col <= {CW{1'b0}};
        r_row <= w_b_last ? {RW{1'b0}} : (r_row + RW'(1));
      end else begin
        r_col <= r_col + CW'(1);
      end
    end else if (w_wr_b) begin
      r_b[r_row] <= bus.data_in;
      r_row      <= w_b_last ? {RW{1'b0}} : (r_row + RW'(1));
    end else if (w_wr_x) begin
      r_x[r_col] <= bus.data_in;
      if (w_col_last) begin
        // Last x word: preload group 0 biases so MAC starts next cycle.
        r_col <= {CW{1'b0}};
        for (int k = 0; k < P; k++) begin
          r_acc[k] <= w_pre[k];
        end
      end else begin
        r_col <= r_col + CW'(1);
      end
    end else if (r_state == MAC) begin
      for (int k = 0; k < P; k++) begin
        r_acc[k] <= w_fin[k];
      end
      if (w_col_last) begin
        // Final column: results go straight to the buffer, entry 0 to the port.
        r_col      <= {CW{1'b0}};
        r_k        <= {KW{1'b0}};
        r_m_valid  <= 1'b1;
        r_data_out <= sat_relu(w_fin[0]);
        for (int k = 0; k < P; k++) begin
          r_obuf[k] <= sat_relu(w_fin[k]);
        end
      end else begin
        r_col <= r_col + CW'(1);
      end
    end else if ((r_state == OUT) && w_out_xfer) begin
      if (w_k_last) begin
        r_m_valid <= 1'b0;
        r_k       <= {KW{1'b0}};
        if (w_grp_last) begin
          r_row <= {RW{1'b0}};
        end else begin
          r_row <= r_row + ROW_STEP;
          for (int k = 0; k < P; k++) begin
            r_acc[k] <= w_pre[k];
          end
        end
      end else begin
        r_k        <= r_k + KW'(1);
        r_data_out <= r_obuf[r_k + KW'(1)];
      end
    end
  end

  assign bus.s_ready  = r_s_ready;
  assign bus.m_valid  = r_m_valid;
  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_fc_layer_param.sv
// tb_fc_layer_param
//   Three instances: A (M=4,N=3,T=16,P=2,RELU=1), B (same, RELU=0) driven in
//   lockstep with A, and C (M=4,N=2,T=8,P=2,RELU=0). sel picks which side the
//   stimulus goes to. Expected outputs come from a plain-arithmetic model of
//   y[r] = clamp(b[r] + sum_c W[r][c]*x[c]) with optional ReLU.
module tb_fc_layer_param;

  localparam int M = 4;
  localparam int P = 2;

  logic        clk;
  logic        rst_n;
  logic        sv;
  logic        lw;
  logic        mr;
  logic [15:0] din;
  int          sel;
  bit          use_gaps;

  int n_checks;
  int n_errors;

  int mw [4][3];
  int mb [4];
  int mx [3];

  fc_layer_param_if #(.T(16)) if_a ();
  fc_layer_param_if #(.T(16)) if_b ();
  fc_layer_param_if #(.T(8))  if_c ();

  assign if_a.s_valid = sv & (sel == 0);
  assign if_b.s_valid = sv & (sel == 0);
  assign if_c.s_valid = sv & (sel == 1);
  assign if_a.load_w  = lw;
  assign if_b.load_w  = lw;
  assign if_c.load_w  = lw;
  assign if_a.data_in = din;
  assign if_b.data_in = din;
  assign if_c.data_in = din[7:0];
  assign if_a.m_ready = mr;
  assign if_b.m_ready = mr;
  assign if_c.m_ready = mr;

  fc_layer_param #(.M(4), .N(3), .T(16), .P(2), .RELU(1)) u_dut_a (
    .clk(clk), .reset(rst_n), .bus(if_a.slave));
  fc_layer_param #(.M(4), .N(3), .T(16), .P(2), .RELU(0)) u_dut_b (
    .clk(clk), .reset(rst_n), .bus(if_b.slave));
  fc_layer_param #(.M(4), .N(2), .T(8), .P(2), .RELU(0)) u_dut_c (
    .clk(clk), .reset(rst_n), .bus(if_c.slave));

  logic tb_sr;
  logic tb_mv;
  assign tb_sr = (sel == 0) ? if_a.s_ready : if_c.s_ready;
  assign tb_mv = (sel == 0) ? if_a.m_valid : if_c.m_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] obs_dout();
    return (sel == 0) ? if_a.data_out : {{8{if_c.data_out[7]}}, if_c.data_out};
  endfunction

  // Reference: saturate to tw bits, optional ReLU.
  function automatic longint ref_y(int r, int nn, int tw, bit relu);
    longint acc, hi, lo;
    acc = mb[r];
    for (int c = 0; c < nn; c++) acc += longint'(mw[r][c]) * longint'(mx[c]);
    hi = (longint'(1) <<< (tw - 1)) - 1;
    lo = -hi - 1;
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    if (relu && acc < 0) acc = 0;
    return acc;
  endfunction

  task automatic send_word(input int val, input bit lwv);
    int gap, w;
    gap = use_gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    sv  = 1'b1;
    lw  = lwv;
    din = 16'(val);
    w = 0;
    while (!tb_sr && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("s_ready_timeout", tb_sr, 1);
    @(posedge clk);
    #1 sv = 1'b0;
  endtask

  task automatic load_coeffs(input int nn);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < nn; c++) send_word(mw[r][c], 1'b1);
    for (int r = 0; r < M; r++) send_word(mb[r], 1'b1);
    lw = 1'b0;
  endtask

  task automatic run_inf(input int nn, input bit stalls);
    int lat, w;
    logic [15:0] held;
    for (int c = 0; c < nn; c++) send_word(mx[c], 1'b0);
    lat = 0;
    @(negedge clk);
    while (!tb_mv && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("first_latency_ok", (lat <= nn + 3), 1);
    for (int r = 0; r < M; r++) begin
      w = 0;
      while (!tb_mv && w < 50) begin
        @(negedge clk);
        w++;
      end
      if ((r % P) != 0) chk("mv_no_drop", w, 0);
      else chk("mv_seen", tb_mv, 1);
      if (stalls && ($urandom_range(0, 1) == 1)) begin
        mr = 1'b0;
        held = obs_dout();
        repeat (2) begin
          @(negedge clk);
          chk("stall_data_hold", obs_dout(), held);
          chk("stall_mv_hold", tb_mv, 1);
        end
      end
      if (sel == 0) begin
        chk("out_relu1", $signed(if_a.data_out), ref_y(r, nn, 16, 1'b1));
        chk("out_relu0", $signed(if_b.data_out), ref_y(r, nn, 16, 1'b0));
      end else begin
        chk("out_t8", $signed(if_c.data_out), ref_y(r, nn, 8, 1'b0));
      end
      mr = 1'b1;
      @(negedge clk);
    end
    mr = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_extra_out", tb_mv, 0);
    chk("back_idle_ready", tb_sr, 1);
  endtask

  task automatic rand_x(input int nn, input int lim);
    for (int c = 0; c < nn; c++) mx[c] = int'($urandom_range(0, 2 * lim)) - lim;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    sv       = 1'b0;
    lw       = 1'b0;
    mr       = 1'b0;
    din      = 16'd0;
    sel      = 0;
    use_gaps = 1'b0;
    foreach (mw[r, c]) mw[r][c] = 0;
    foreach (mb[r]) mb[r] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_ready_a", if_a.s_ready, 0);
    chk("rst_s_ready_c", if_c.s_ready, 0);
    chk("rst_m_valid_a", if_a.m_valid, 0);
    chk("rst_m_valid_c", if_c.m_valid, 0);
    chk("rst_dout_a", if_a.data_out, 0);
    chk("rst_dout_c", if_c.data_out, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("s_ready_first_edge_a", if_a.s_ready, 1);
    chk("s_ready_first_edge_c", if_c.s_ready, 1);

    // T=8 instance: inference from reset coefficients, then saturation cases
    sel = 1;
    rand_x(2, 100);
    run_inf(2, 1'b0);
    foreach (mw[r, c]) mw[r][c] = 127;
    foreach (mb[r]) mb[r] = 0;
    load_coeffs(2);
    mx[0] = 127; mx[1] = 127;
    run_inf(2, 1'b0);
    mx[0] = -128; mx[1] = -128;
    run_inf(2, 1'b0);

    // Directed A/B case and back-to-back inference
    sel = 0;
    foreach (mw[r, c]) mw[r][c] = 1;
    mb[0] = 0; mb[1] = 1; mb[2] = -10; mb[3] = 2;
    load_coeffs(3);
    mx[0] = 1; mx[1] = 2; mx[2] = 3;
    run_inf(3, 1'b0);
    mx[0] = 0; mx[1] = 0; mx[2] = 1;
    run_inf(3, 1'b0);

    // Same coefficients under s_valid gaps and m_ready stalls
    use_gaps = 1'b1;
    mx[0] = 1; mx[1] = 2; mx[2] = 3;
    run_inf(3, 1'b1);

    // Random coefficients, two inferences per load (coefficients persist)
    for (int it = 0; it < 6; it++) begin
      int wl, bl;
      wl = (it % 2 == 0) ? 40 : 300;
      bl = (it % 2 == 0) ? 500 : 20000;
      foreach (mw[r, c]) mw[r][c] = int'($urandom_range(0, 2 * wl)) - wl;
      foreach (mb[r]) mb[r] = int'($urandom_range(0, 2 * bl)) - bl;
      load_coeffs(3);
      rand_x(3, wl);
      run_inf(3, 1'b1);
      rand_x(3, 300);
      run_inf(3, 1'b1);
    end

    // Random on the T=8 instance
    sel = 1;
    for (int it = 0; it < 3; it++) begin
      foreach (mw[r, c]) mw[r][c] = int'($urandom_range(0, 30)) - 15;
      foreach (mb[r]) mb[r] = int'($urandom_range(0, 200)) - 100;
      load_coeffs(2);
      rand_x(2, 128);
      if (mx[0] > 127) mx[0] = 127;
      if (mx[1] > 127) mx[1] = 127;
      run_inf(2, 1'b1);
    end

    // Reset during the second output word of A/B
    sel = 0;
    use_gaps = 1'b0;
    foreach (mw[r, c]) mw[r][c] = 1;
    mb[0] = 0; mb[1] = 1; mb[2] = -10; mb[3] = 2;
    load_coeffs(3);
    mx[0] = 1; mx[1] = 2; mx[2] = 3;
    for (int c = 0; c < 3; c++) send_word(mx[c], 1'b0);
    begin
      int w;
      w = 0;
      while (!tb_mv && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("pre_rst_first_valid", tb_mv, 1);
      mr = 1'b1;
      @(negedge clk);
      chk("pre_rst_second_valid", tb_mv, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_abort_mv_a", if_a.m_valid, 0);
      chk("rst_abort_mv_b", if_b.m_valid, 0);
      chk("rst_abort_dout_a", if_a.data_out, 0);
      chk("rst_abort_s_ready", if_a.s_ready, 0);
      mr = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_hold_mv", if_a.m_valid, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("s_ready_after_rerelease", if_a.s_ready, 1);
    end
    foreach (mw[r, c]) mw[r][c] = 0;
    foreach (mb[r]) mb[r] = 0;
    rand_x(3, 300);
    run_inf(3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
